// File: rtl/frac_div_pkg.sv
// Shared constants and helpers for the fractional-N divider controller.
// Optional build macro used by frac_div_ctrl: FRAC_DIV_DUTY50_EN.
package frac_div_pkg;

    localparam int DS_WIDTH = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Modulator output is signed two's complement; widen it for ratio arithmetic.
    function automatic int sext_ds(input logic [DS_WIDTH-1:0] y);
        return int'($signed(y));
    endfunction

endpackage

// File: rtl/frac_div_ratio_calc.sv
// Combinational ratio R = n_int + y with clamping to [N_MIN, 2^N_WIDTH-1].
// sat_o flags that either clamp bound was applied.
module frac_div_ratio_calc
    import frac_div_pkg::*;
#(
    parameter int N_WIDTH = 8,
    parameter int N_MIN   = 4
) (
    input  logic [N_WIDTH-1:0]  n_int_i,
    input  logic [DS_WIDTH-1:0] ds_y_i,
    output logic [N_WIDTH-1:0]  ratio_o,
    output logic                sat_o
);

    localparam int RW = N_WIDTH + 2;
    localparam logic signed [RW-1:0] R_MIN = RW'(N_MIN);
    localparam logic signed [RW-1:0] R_MAX = RW'((1 << N_WIDTH) - 1);

    logic signed [RW-1:0] w_raw;

    // Two guard bits keep the sum exact for both underflow and overflow.
    always_comb begin
        w_raw   = $signed({2'b00, n_int_i}) + RW'(sext_ds(ds_y_i));
        ratio_o = w_raw[N_WIDTH-1:0];
        sat_o   = 1'b0;
        if (w_raw < R_MIN) begin
            ratio_o = R_MIN[N_WIDTH-1:0];
            sat_o   = 1'b1;
        end else if (w_raw > R_MAX) begin
            ratio_o = R_MAX[N_WIDTH-1:0];
            sat_o   = 1'b1;
        end
    end

endmodule

// File: rtl/frac_div_ctrl.sv
// Fractional-N divider controller: divides clk by R = n_int_i + ds_y_i per period.
// Define FRAC_DIV_DUTY50_EN for a ~50% duty div_o instead of a terminal pulse.
module frac_div_ctrl
    import frac_div_pkg::*;
#(
    parameter int N_WIDTH = 8,
    parameter int N_MIN   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic [N_WIDTH-1:0]  n_int_i,
    input  logic [DS_WIDTH-1:0] ds_y_i,
    output logic                ds_step_o,
    output logic                div_o,
    output logic [N_WIDTH-1:0]  ratio_o,
    output logic                sat_o
);

    logic [0:0]         r_state;
    logic [N_WIDTH-1:0] r_cnt;
    logic [N_WIDTH-1:0] r_ratio;
    logic               r_sat;
    logic               r_step;

    logic [N_WIDTH-1:0] w_ratio;
    logic               w_sat;
    logic               w_terminal;
    logic               w_load;

    frac_div_ratio_calc #(
        .N_WIDTH (N_WIDTH),
        .N_MIN   (N_MIN)
    ) u_ratio_calc (
        .n_int_i (n_int_i),
        .ds_y_i  (ds_y_i),
        .ratio_o (w_ratio),
        .sat_o   (w_sat)
    );

    assign w_terminal = (r_state == ST_RUN) && (r_cnt == '0);
    assign w_load     = en_i && ((r_state == ST_IDLE) || w_terminal);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ratio <= '0;
            r_sat   <= 1'b0;
            r_step  <= 1'b0;
        end else begin
            // Strobe is registered so no input reaches an output combinationally.
            r_step <= w_load;
            if (w_load) begin
                r_state <= ST_RUN;
                r_cnt   <= w_ratio - N_WIDTH'(1);
                r_ratio <= w_ratio;
                r_sat   <= (r_state == ST_IDLE) ? w_sat : (r_sat | w_sat);
            end else if (r_state == ST_RUN) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - N_WIDTH'(1);
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign ds_step_o = r_step;
    assign ratio_o   = r_ratio;
    assign sat_o     = r_sat;

`ifdef FRAC_DIV_DUTY50_EN
    assign div_o = (r_state == ST_RUN) && (r_cnt > ((r_ratio - N_WIDTH'(1)) >> 1));
`else
    assign div_o = w_terminal;
`endif

endmodule
